// File: rtl/flit_sink_if.sv
// Flit stream bundle carried from a mux or router egress into a sink.
// Latency: none, wires only.
// Backpressure: none; a flit is taken every cycle ivalid is high.
interface flit_sink_if #(
  parameter int PAYW  = 64,
  parameter int TYPEW = 2,
  parameter int VCHW  = 1
);
  logic [TYPEW+PAYW-1:0] idata;
  logic                  ivalid;
  logic [VCHW-1:0]       ivch;

  modport master (output idata, output ivalid, output ivch);
  modport slave  (input  idata, input  ivalid, input  ivch);
endinterface

// File: rtl/flit_sink.sv
// Flit sink: per-VC head/data/tail framing, packet/flit/toggle counters, sticky error flags.
// Latency: 1 cycle from a sampled flit to every registered output.
// Backpressure: none; every valid flit is accepted, back-to-back on any VC.
module flit_sink #(
  parameter int PAYW  = 64,
  parameter int TYPEW = 2,
  parameter int VCHW  = 1,
  parameter int CNTW  = 32,
  localparam int NVC  = 1 << VCHW
) (
  input  logic              clk,
  input  logic              rst_,
  flit_sink_if.slave        flit,
  input  logic              clr,
  output logic [CNTW-1:0]   pkt_cnt,
  output logic [CNTW-1:0]   flit_cnt,
  output logic [CNTW-1:0]   tgl_cnt,
  output logic [15:0]       last_len,
  output logic [NVC-1:0]    busy,
  output logic [3:0]        err
);

  localparam int FW  = TYPEW + PAYW;
  localparam int PCW = $clog2(FW + 1);

  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(2);
  localparam logic [TYPEW-1:0] T_DATA = TYPEW'(3);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  // Per-VC framing state and length
  logic [NVC-1:0] state_q, state_d;
  logic [15:0]    len_q [NVC];
  logic [15:0]    len_d [NVC];

  // Statistics and history
  logic [CNTW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNTW-1:0] flit_cnt_q, flit_cnt_d;
  logic [CNTW-1:0] tgl_cnt_q, tgl_cnt_d;
  logic [15:0]     last_len_q, last_len_d;
  logic [3:0]      err_q, err_d;
  logic [FW-1:0]   prev_q, prev_d;
  logic            prev_vld_q, prev_vld_d;

  // Decode helpers
  logic [TYPEW-1:0] ftype;
  logic [VCHW-1:0]  vc;
  logic [15:0]      len_cur;
  logic [15:0]      len_inc;
  logic             tail_hit;
  logic [15:0]      done_len;
  logic             e_idle, e_head, e_none;

  // Toggle datapath
  logic [FW-1:0]   diff;
  logic [PCW-1:0]  pop;
  logic [CNTW:0]   tgl_sum;
  logic [CNTW-1:0] tgl_next;

  assign ftype   = flit.idata[FW-1:PAYW];
  assign vc      = flit.ivch;
  assign len_cur = len_q[vc];
  assign len_inc = (len_cur == 16'hFFFF) ? 16'hFFFF : len_cur + 16'd1;
  assign diff    = flit.idata ^ prev_q;

  // Framing FSM of the addressed VC; runs even while clr is held so packets in flight survive
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    tail_hit = 1'b0;
    done_len = 16'd0;
    e_idle   = 1'b0;
    e_head   = 1'b0;
    e_none   = 1'b0;
    if (flit.ivalid) begin
      if (ftype == T_NONE) begin
        e_none = 1'b1;
      end else if (state_q[vc] == ST_IDLE) begin
        if (ftype == T_HEAD) begin
          state_d[vc] = ST_BODY;
          len_d[vc]   = 16'd1;
        end else begin
          e_idle = 1'b1;
        end
      end else begin
        case (ftype)
          T_HEAD: begin
            // A new head mid-packet abandons the old one and restarts framing
            e_head    = 1'b1;
            len_d[vc] = 16'd1;
          end
          T_DATA: begin
            len_d[vc] = len_inc;
          end
          T_TAIL: begin
            state_d[vc] = ST_IDLE;
            tail_hit    = 1'b1;
            done_len    = len_inc;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Hamming distance to the previous valid flit, summed one extra bit wide and clamped
  always_comb begin
    pop = '0;
    for (int i = 0; i < FW; i++) begin
      pop = pop + PCW'(diff[i]);
    end
    tgl_sum  = {1'b0, tgl_cnt_q} + (CNTW+1)'(pop);
    tgl_next = tgl_sum[CNTW] ? {CNTW{1'b1}} : tgl_sum[CNTW-1:0];
  end

  // Counters, last length, history and sticky errors; clr wins over a concurrent flit
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    tgl_cnt_d  = tgl_cnt_q;
    last_len_d = last_len_q;
    err_d      = err_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (clr) begin
      pkt_cnt_d  = '0;
      flit_cnt_d = '0;
      tgl_cnt_d  = '0;
      last_len_d = '0;
      err_d      = '0;
      prev_vld_d = 1'b0;
    end else if (flit.ivalid) begin
      flit_cnt_d = (flit_cnt_q == {CNTW{1'b1}}) ? flit_cnt_q : flit_cnt_q + CNTW'(1);
      if (prev_vld_q) begin
        tgl_cnt_d = tgl_next;
      end
      prev_d     = flit.idata;
      prev_vld_d = 1'b1;
      if (tail_hit) begin
        pkt_cnt_d  = (pkt_cnt_q == {CNTW{1'b1}}) ? pkt_cnt_q : pkt_cnt_q + CNTW'(1);
        last_len_d = done_len;
      end
      err_d[0] = err_q[0] | e_idle;
      err_d[1] = err_q[1] | e_head;
      err_d[2] = err_q[2] | e_none;
      err_d[3] = err_q[3] | (pkt_cnt_d == {CNTW{1'b1}}) | (flit_cnt_d == {CNTW{1'b1}})
                          | (tgl_cnt_d == {CNTW{1'b1}});
    end
  end

  // State registers; reset drops any packet in flight
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= '0;
      len_q      <= '{default: '0};
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
      tgl_cnt_q  <= '0;
      last_len_q <= '0;
      err_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
      tgl_cnt_q  <= tgl_cnt_d;
      last_len_q <= last_len_d;
      err_q      <= err_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;
  assign tgl_cnt  = tgl_cnt_q;
  assign last_len = last_len_q;
  assign busy     = state_q;
  assign err      = err_q;

endmodule
